seg7_word_reader: RTL

Receive-side counterpart of the `seg7` letter decoder. It samples a 7-segment pattern bus and filters each pattern for stability. Each stable pattern is encoded back to the 4-bit letter code the decoder accepts. A sequence tracker then reports each complete spelling of C-L-A-U-D-I-A. It sits at the loopback/self-test point after the display driver, or at the input of a board that snoops another board's segment lines.

---
 rtl/seg7_word_reader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_word_reader.sv
// seg7_word_reader: samples a 7-segment bus, accepts each pattern once it has
// been stable for STABLE_CYCLES valid samples, maps it back to the 4-bit
// letter code and tracks complete spellings of C-L-A-U-D-I-A.
//
// Input qualification: seg_in is consumed only on cycles where seg_valid is
// high. There is no back-pressure; a low seg_valid simply breaks the current
// stable run. Output pulses (code_valid, code_err, word_done) are single-cycle
// strobes with no ready signal; code_out, pos and word_count are levels.
module seg7_word_reader #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             seg_valid,
  output logic [3:0]       code_out,
  output logic             code_valid,
  output logic             code_err,
  output logic [2:0]       pos,
  output logic             word_done,
  output logic [CNT_W-1:0] word_count
);

  // Segment patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] PAT_C     = 7'b0111001;
  localparam logic [6:0] PAT_L     = 7'b0111000;
  localparam logic [6:0] PAT_A     = 7'b1110111;
  localparam logic [6:0] PAT_U     = 7'b0111110;
  localparam logic [6:0] PAT_D     = 7'b0111111;
  localparam logic [6:0] PAT_I     = 7'b0000110;
  localparam logic [6:0] PAT_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_UNKNOWN = 4'hF;

  // Run counter saturates at the threshold, so 4 bits cover the 1..15 range.
  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  // Word tracker position; the encoding doubles as the pos output.
  typedef enum logic [2:0] {
    POS_0 = 3'd0,
    POS_1 = 3'd1,
    POS_2 = 3'd2,
    POS_3 = 3'd3,
    POS_4 = 3'd4,
    POS_5 = 3'd5,
    POS_6 = 3'd6
  } pos_e;

  // Letter code expected at each tracker position.
  function automatic logic [3:0] expected_code(input pos_e p);
    logic [3:0] c;
    case (p)
      POS_0:   c = 4'd0;
      POS_1:   c = 4'd1;
      POS_2:   c = 4'd2;
      POS_3:   c = 4'd3;
      POS_4:   c = 4'd4;
      POS_5:   c = 4'd5;
      POS_6:   c = 4'd2;
      default: c = 4'd0;
    endcase
    return c;
  endfunction

  // Position that follows a correct letter at p (POS_6 wraps via word_done).
  function automatic pos_e advance(input pos_e p);
    pos_e n;
    case (p)
      POS_0:   n = POS_1;
      POS_1:   n = POS_2;
      POS_2:   n = POS_3;
      POS_3:   n = POS_4;
      POS_4:   n = POS_5;
      POS_5:   n = POS_6;
      default: n = POS_0;
    endcase
    return n;
  endfunction

  // Stability filter state.
  logic [6:0] held_q, held_d;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       accept;

  // Pattern decode of the held pattern.
  logic [3:0] dec_code;
  logic       dec_letter;
  logic       dec_blank;

  // Tracker and output registers.
  pos_e             state_q, state_d;
  logic [3:0]       code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;
  logic             code_err_q, code_err_d;
  logic             word_done_q, word_done_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  // Stability filter: track the current run and flag a single acceptance
  // when the run first reaches the threshold.
  always_comb begin
    held_d  = held_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    accept  = 1'b0;
    if (!seg_valid) begin
      cnt_d   = 4'd0;
      armed_d = 1'b1;
    end else if ((seg_in != held_q) || (cnt_q == 4'd0)) begin
      held_d  = seg_in;
      cnt_d   = 4'd1;
      armed_d = 1'b1;
    end else if (cnt_q != STABLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Armed clears on acceptance so a held pattern is reported only once.
    if (seg_valid && armed_d && (cnt_d == STABLE_C)) begin
      accept  = 1'b1;
      armed_d = 1'b0;
    end
  end

  // Map the pattern being accepted back to its letter code.
  always_comb begin
    dec_code   = CODE_UNKNOWN;
    dec_letter = 1'b0;
    dec_blank  = 1'b0;
    case (held_d)
      PAT_C:     begin dec_code = 4'd0; dec_letter = 1'b1; end
      PAT_L:     begin dec_code = 4'd1; dec_letter = 1'b1; end
      PAT_A:     begin dec_code = 4'd2; dec_letter = 1'b1; end
      PAT_U:     begin dec_code = 4'd3; dec_letter = 1'b1; end
      PAT_D:     begin dec_code = 4'd4; dec_letter = 1'b1; end
      PAT_I:     begin dec_code = 4'd5; dec_letter = 1'b1; end
      PAT_BLANK: dec_blank = 1'b1;
      default:   dec_code = CODE_UNKNOWN;
    endcase
  end

  // Tracker next state and output pulses for each accepted pattern.
  always_comb begin
    state_d      = state_q;
    code_out_d   = code_out_q;
    code_valid_d = 1'b0;
    code_err_d   = 1'b0;
    word_done_d  = 1'b0;
    word_count_d = word_count_q;
    if (accept) begin
      if (dec_letter) begin
        code_out_d   = dec_code;
        code_valid_d = 1'b1;
        if (dec_code == expected_code(state_q)) begin
          if (state_q == POS_6) begin
            word_done_d  = 1'b1;
            word_count_d = word_count_q + 1'b1;
            state_d      = POS_0;
          end else begin
            state_d = advance(state_q);
          end
        end else if (dec_code == 4'd0) begin
          // A stray C is itself the start of a new word.
          state_d = POS_1;
        end else begin
          state_d = POS_0;
        end
      end else if (!dec_blank) begin
        code_out_d = CODE_UNKNOWN;
        code_err_d = 1'b1;
        state_d    = POS_0;
      end
      // Blank: a gap between letters, nothing changes.
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q       <= PAT_BLANK;
      cnt_q        <= 4'd0;
      armed_q      <= 1'b1;
      state_q      <= POS_0;
      code_out_q   <= 4'd0;
      code_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      word_done_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
      code_err_q   <= code_err_d;
      word_done_q  <= word_done_d;
      word_count_q <= word_count_d;
    end
  end

  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign code_err   = code_err_q;
  assign pos        = state_q;
  assign word_done  = word_done_q;
  assign word_count = word_count_q;

endmodule
